tbird_sequencer: RTL
====================

// Module: tbird_sequencer
// PURPOSE
//   Parametrised tail-light sequencer: drives LIGHTS_PER_SIDE lamps per side for left/right
//   turn, hazard and (optionally) brake. Adds a selectable fill/chase pattern and
//   single-clock-domain stepping on an enable tick. Sits between button decode and LED pins.
// PARAMETERS
//   LIGHTS_PER_SIDE  3  lamps per side, legal range 1..16
//   SEQ_MODE         0  0 = fill (lamps accumulate outward), 1 = chase (one lamp walks outward)
// PORTS
//   clock        in   1  system clock; every flop is on posedge clock
//   reset        in   1  asynchronous, active-high; forces reset state immediately
//   enable       in   1  step tick, synchronous to clock; each clock with enable=1 is one step
//   left_req     in   1  left-turn request, level, active-high
//   right_req    in   1  right-turn request, level, active-high
//   hazard_req   in   1  hazard request, level, active-high
//   brake        in   1  brake, level, active-high (present only with TBIRD_BRAKE_EN)
//   lights_left  out  N  left lamps, N = LIGHTS_PER_SIDE; bit 0 = innermost lamp
//   lights_right out  N  right lamps; bit 0 = innermost lamp
// BEHAVIOUR
//   - Reset: state=IDLE, step=0, lights_left=0, lights_right=0.
//   - Outputs are registered. Requests are sampled only on enable cycles. Outputs change on the
//     same edge that samples enable=1, so they are visible 1 clock after the tick.
//   - States: IDLE, LEFT, RIGHT, HAZARD. step counter width = $clog2(N+1), range 0..N.
//   - Request priority at each tick: hazard_req, or (left_req & right_req) -> HAZARD;
//     otherwise left_req -> LEFT; otherwise right_req -> RIGHT.
//   - IDLE: on a LEFT/RIGHT request go to that state with step=1. On a hazard request go to
//     HAZARD with all lamps on.
//   - LEFT/RIGHT: each tick step advances 1..N, then 0. Step 0 is the all-off phase, so the
//     period is N+1 ticks.
//     - Fill pattern: lowest `step` bits set. Chase pattern: only bit step-1 set.
//     - The opposite side is held at 0.
//     - Releasing the request does not abort: the sequence runs to step 0, then goes to IDLE.
//     - At step 0 with the request still held, the sequence restarts at step 1 on the next tick.
//     - An opposite-direction request mid-sequence aborts: at that tick, switch direction with
//       step=1.
//   - HAZARD: entered at any tick from any state when hazard is requested (pre-empts immediately).
//     - Both sides toggle each tick between all-on and all-off; entry phase is all-on.
//     - When the request drops, the next tick gives all-off and IDLE.
//   - No tick means state, step and lights hold.
//   - Reset mid-sequence returns to IDLE/off asynchronously.
// CONFIGURATION
//   TBIRD_BRAKE_EN defined:
//     - brake port exists. Brake is applied every clock (not tick-gated), with 1-clock latency.
//     - IDLE: both sides all-on. LEFT: right side all-on. RIGHT: left side all-on.
//     - HAZARD: brake has no effect. Releasing brake restores the sequencer pattern next clock.
//     - Step and state are never disturbed by brake.
//   TBIRD_BRAKE_EN undefined: no brake port, and no brake logic remains.
// STRUCTURE
//   tbird_pkg: state typedef (IDLE/LEFT/RIGHT/HAZARD), SEQ_FILL=0 / SEQ_CHASE=1 constants.
//   Sub-module tbird_side_pattern (combinational step -> N-bit pattern, SEQ_MODE param).
//   It is instantiated once and muxed onto the active side. FSM, step counter and output
//   registers live in the top.
// TESTING (N=3 unless noted)
//   1. Hold left_req, 5 ticks, fill mode -> lights_left 001,011,111,000,001; lights_right 000.
//   2. left_req high for one tick only -> 001,011,111,000, then IDLE, off on all later ticks.
//   3. hazard_req rises during RIGHT step 2 -> next tick 111/111, then 000/000, 111/111;
//      drop hazard_req -> 000/000, IDLE.
//   4. N=4, SEQ_MODE=1, hold right_req -> lights_right 0001,0010,0100,1000,0000.
//   5. Assert reset between ticks during LEFT step 2 -> lights 000/000 before the next clock
//      edge; first tick after release with left_req high -> 001.
//   6. TBIRD_BRAKE_EN, LEFT running, brake=1 -> lights_right=111 one clock later;
//      lights_left keeps stepping; brake=0 -> right=000.

Source files
------------

// File: rtl/tbird_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tbird_pkg
//  Description : Shared types and constants for the tail-light sequencer:
//                sequencer state encoding and fill/chase pattern selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package tbird_pkg;

    // Sequencer states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } tbird_state_t;

    // Pattern selectors for the SEQ_MODE parameter
    localparam int SEQ_FILL  = 0;
    localparam int SEQ_CHASE = 1;

endpackage
`default_nettype wire

// File: rtl/tbird_side_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : tbird_side_pattern
//  Description : Combinational step-to-lamp decoder for one side. Fill mode
//                lights the lowest `step` lamps; chase mode lights only lamp
//                step-1. Step 0 gives all lamps off in both modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tbird_side_pattern
    import tbird_pkg::*;
#(
    parameter int LIGHTS_PER_SIDE = 3,
    parameter int SEQ_MODE        = SEQ_FILL
) (
    input  logic [$clog2(LIGHTS_PER_SIDE+1)-1:0] i_step,
    output logic [LIGHTS_PER_SIDE-1:0]           o_pattern
);

    localparam int STEP_W = $clog2(LIGHTS_PER_SIDE + 1);

    if (SEQ_MODE == SEQ_CHASE) begin : g_chase
        // A single lamp walks outward: lamp i is lit only at step i+1
        for (genvar i = 0; i < LIGHTS_PER_SIDE; i++) begin : g_bit
            assign o_pattern[i] = (i_step == STEP_W'(i + 1));
        end
    end else begin : g_fill
        // Lamps accumulate outward: lamp i is lit once step exceeds i
        for (genvar i = 0; i < LIGHTS_PER_SIDE; i++) begin : g_bit
            assign o_pattern[i] = (i_step > STEP_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/tbird_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tbird_sequencer
//  Description : Parametrised tail-light sequencer. Steps left/right turn
//                sequences and hazard flashing on an enable tick; lamp
//                outputs are registered. Optional brake overlay is built
//                when the macro TBIRD_BRAKE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tbird_sequencer
    import tbird_pkg::*;
#(
    parameter int LIGHTS_PER_SIDE = 3,
    parameter int SEQ_MODE        = SEQ_FILL
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       left_req,
    input  logic                       right_req,
    input  logic                       hazard_req,
`ifdef TBIRD_BRAKE_EN
    input  logic                       brake,
`endif
    output logic [LIGHTS_PER_SIDE-1:0] lights_left,
    output logic [LIGHTS_PER_SIDE-1:0] lights_right
);

    localparam int                         STEP_W    = $clog2(LIGHTS_PER_SIDE + 1);
    localparam logic [STEP_W-1:0]          STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0]          STEP_LAST = STEP_W'(LIGHTS_PER_SIDE);
    localparam logic [LIGHTS_PER_SIDE-1:0] ALL_ON    = '1;

    tbird_state_t                r_state;
    tbird_state_t                w_state_nxt;
    logic [STEP_W-1:0]           r_step;
    logic [STEP_W-1:0]           w_step_nxt;
    logic                        w_haz_req;
    logic [LIGHTS_PER_SIDE-1:0]  w_pattern;
    logic [LIGHTS_PER_SIDE-1:0]  w_left_nxt;
    logic [LIGHTS_PER_SIDE-1:0]  w_right_nxt;

    // Both turn buttons together count as a hazard request
    assign w_haz_req = hazard_req | (left_req & right_req);

    // One shared decoder; its pattern is steered onto the active side.
    // In HAZARD, step only carries the on/off phase (1 = on, 0 = off).
    tbird_side_pattern #(
        .LIGHTS_PER_SIDE (LIGHTS_PER_SIDE),
        .SEQ_MODE        (SEQ_MODE)
    ) u_pattern (
        .i_step    (w_step_nxt),
        .o_pattern (w_pattern)
    );

    // State and step register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Next-state and next-step decision, evaluated only on enable ticks
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        if (enable) begin
            if (w_haz_req) begin
                // Hazard pre-empts everything; entry phase is all-on
                w_state_nxt = HAZARD;
                w_step_nxt  = (r_state == HAZARD && r_step != '0) ? '0 : STEP_ONE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (left_req) begin
                            w_state_nxt = LEFT;
                            w_step_nxt  = STEP_ONE;
                        end else if (right_req) begin
                            w_state_nxt = RIGHT;
                            w_step_nxt  = STEP_ONE;
                        end
                    end
                    LEFT: begin
                        if (right_req) begin
                            w_state_nxt = RIGHT;
                            w_step_nxt  = STEP_ONE;
                        end else if (r_step == '0) begin
                            // End of the off phase: restart if still held
                            w_state_nxt = left_req ? LEFT : IDLE;
                            w_step_nxt  = left_req ? STEP_ONE : '0;
                        end else if (r_step == STEP_LAST) begin
                            w_step_nxt = '0;
                        end else begin
                            w_step_nxt = r_step + STEP_ONE;
                        end
                    end
                    RIGHT: begin
                        if (left_req) begin
                            w_state_nxt = LEFT;
                            w_step_nxt  = STEP_ONE;
                        end else if (r_step == '0) begin
                            w_state_nxt = right_req ? RIGHT : IDLE;
                            w_step_nxt  = right_req ? STEP_ONE : '0;
                        end else if (r_step == STEP_LAST) begin
                            w_step_nxt = '0;
                        end else begin
                            w_step_nxt = r_step + STEP_ONE;
                        end
                    end
                    HAZARD: begin
                        // Request dropped: one all-off tick back to IDLE
                        w_state_nxt = IDLE;
                        w_step_nxt  = '0;
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_step_nxt  = '0;
                    end
                endcase
            end
        end
    end

    // Lamp values for the next clock, from the upcoming state/step
    always_comb begin
        w_left_nxt  = '0;
        w_right_nxt = '0;
        case (w_state_nxt)
            LEFT:    w_left_nxt  = w_pattern;
            RIGHT:   w_right_nxt = w_pattern;
            HAZARD: begin
                if (w_step_nxt != '0) begin
                    w_left_nxt  = ALL_ON;
                    w_right_nxt = ALL_ON;
                end
            end
            default: begin
                w_left_nxt  = '0;
                w_right_nxt = '0;
            end
        endcase
`ifdef TBIRD_BRAKE_EN
        // Brake lights every side not busy signalling; hazard is left alone
        if (brake) begin
            case (w_state_nxt)
                IDLE: begin
                    w_left_nxt  = ALL_ON;
                    w_right_nxt = ALL_ON;
                end
                LEFT:    w_right_nxt = ALL_ON;
                RIGHT:   w_left_nxt  = ALL_ON;
                default: begin
                end
            endcase
        end
`endif
    end

    // Registered lamp outputs, updated every clock so brake acts untied from enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lights_left  <= '0;
            lights_right <= '0;
        end else begin
            lights_left  <= w_left_nxt;
            lights_right <= w_right_nxt;
        end
    end

endmodule
`default_nettype wire
